// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback controller.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 31;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  // 'reg' is a keyword, so the destination field is named dst.
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU, bit 1 the load path.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  wb_src_t rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    grant[0] = req[0] & (~req[1] | (rr_ptr_q == WB_ALU));
    grant[1] = req[1] & (~req[0] | (rr_ptr_q == WB_MEM));
    // Only a conflict moves the pointer; a lone requester leaves it alone.
    if (&req) begin
      rr_ptr_d = grant[0] ? WB_MEM : WB_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= WB_ALU;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter, pending scoreboard and write stage for the single-port register file.
// Define REGFILE_WB_FORWARD_EN to forward the write-stage value instead of stalling on it.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned REG_AW   = regfile_pkg::REG_AW,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aluValid,
  input  logic [REG_AW-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [REG_AW-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              issueValid,
  input  logic [REG_AW-1:0] issueReg,
  output logic              issueReady,
  input  logic [REG_AW-1:0] register1,
  input  logic [REG_AW-1:0] register2,
  output logic              readStall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              fwdSel1,
  output logic              fwdSel2,
  output logic [DATA_W-1:0] fwdData
);
  import regfile_pkg::*;

  localparam logic [REG_AW-1:0] ZeroAddr = REG_AW'(ZERO_REG);

  logic [1:0]          grant;
  wb_src_t             win_src;
  logic                win_valid;
  logic [REG_AW-1:0]   win_reg;
  logic [DATA_W-1:0]   win_data;
  logic                reg_write_q, reg_write_d;
  logic [REG_AW-1:0]   wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                issue_fire;
  logic                hazard1, hazard2;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({memValid, aluValid}),
    .grant (grant)
  );

  assign aluReady  = grant[0];
  assign memReady  = grant[1];
  assign win_valid = |grant;
  assign win_src   = grant[1] ? WB_MEM : WB_ALU;
  assign win_reg   = (win_src == WB_MEM) ? memReg : aluReg;
  assign win_data  = (win_src == WB_MEM) ? memData : aluData;

  assign issueReady = (issueReg == ZeroAddr) || !pending_q[issueReg];
  assign issue_fire = issueValid && issueReady && (issueReg != ZeroAddr);

  always_comb begin
    reg_write_d = win_valid && (win_reg != ZeroAddr);
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (reg_write_d) begin
      wr_reg_d  = win_reg;
      wr_data_d = win_data;
    end
  end

  // Clear before set so a fresh producer wins should both ever name one register.
  always_comb begin
    pending_d = pending_q;
    if (win_valid && (win_reg != ZeroAddr)) begin
      pending_d[win_reg] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[issueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign writeRegister = wr_reg_q;
  assign writeData     = wr_data_q;

  always_comb begin
`ifdef REGFILE_WB_FORWARD_EN
    hazard1 = (register1 != ZeroAddr) && pending_q[register1];
    hazard2 = (register2 != ZeroAddr) && pending_q[register2];
    fwdSel1 = reg_write_q && (wr_reg_q == register1) && (register1 != ZeroAddr);
    fwdSel2 = reg_write_q && (wr_reg_q == register2) && (register2 != ZeroAddr);
    fwdData = wr_data_q;
`else
    hazard1 = (register1 != ZeroAddr) &&
              (pending_q[register1] || (reg_write_q && (wr_reg_q == register1)));
    hazard2 = (register2 != ZeroAddr) &&
              (pending_q[register2] || (reg_write_q && (wr_reg_q == register2)));
    fwdSel1 = 1'b0;
    fwdSel2 = 1'b0;
    fwdData = '0;
`endif
  end

  assign readStall = hazard1 || hazard2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; register-file writes are checked through a scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              aluValid;
  logic [REG_AW-1:0] aluReg;
  logic [DATA_W-1:0] aluData;
  logic              aluReady;
  logic              memValid;
  logic [REG_AW-1:0] memReg;
  logic [DATA_W-1:0] memData;
  logic              memReady;
  logic              issueValid;
  logic [REG_AW-1:0] issueReg;
  logic              issueReady;
  logic [REG_AW-1:0] register1;
  logic [REG_AW-1:0] register2;
  logic              readStall;
  logic              RegWrite;
  logic [REG_AW-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              fwdSel1;
  logic              fwdSel2;
  logic [DATA_W-1:0] fwdData;

  int n_tests = 0;
  int n_fail  = 0;
  wb_req_t exp_q[$];

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluValid      (aluValid),
    .aluReg        (aluReg),
    .aluData       (aluData),
    .aluReady      (aluReady),
    .memValid      (memValid),
    .memReg        (memReg),
    .memData       (memData),
    .memReady      (memReady),
    .issueValid    (issueValid),
    .issueReg      (issueReg),
    .issueReady    (issueReady),
    .register1     (register1),
    .register2     (register2),
    .readStall     (readStall),
    .RegWrite      (RegWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .fwdSel1       (fwdSel1),
    .fwdSel2       (fwdSel2),
    .fwdData       (fwdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic av, input logic [REG_AW-1:0] ar, input logic [DATA_W-1:0] ad,
                          input logic mv, input logic [REG_AW-1:0] mr, input logic [DATA_W-1:0] md);
    aluValid = av;
    aluReg   = ar;
    aluData  = ad;
    memValid = mv;
    memReg   = mr;
    memData  = md;
  endtask

  task automatic expect_write(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    wb_req_t e;
    e.dst  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && RegWrite) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                 writeRegister, writeData);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("wb_reg", 32'(writeRegister), 32'(e.dst));
        check("wb_data", writeData, e.data);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    issueValid = 1'b0;
    issueReg   = '0;
    register1  = '0;
    register2  = '0;
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    check("reset_wreg", 32'(writeRegister), 32'd0);
    check("reset_wdata", writeData, 32'd0);
    check("reset_stall", 32'(readStall), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // ALU alone.
    drive_wb(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    #1;
    check("alu_only_ready", 32'(aluReady), 32'd1);
    check("alu_only_mem_ready", 32'(memReady), 32'd0);
    expect_write(5'd5, 32'h1234);
    tick();
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    register1 = 5'd5;
    #1;
    check("alu_only_regwrite", 32'(RegWrite), 32'd1);
    check("alu_only_wreg", 32'(writeRegister), 32'd5);
`ifdef REGFILE_WB_FORWARD_EN
    check("wstage_stall_fwd", 32'(readStall), 32'd0);
    check("wstage_fwdsel1", 32'(fwdSel1), 32'd1);
    check("wstage_fwddata", fwdData, 32'h1234);
`else
    check("wstage_stall", 32'(readStall), 32'd1);
    check("wstage_fwdsel1", 32'(fwdSel1), 32'd0);
`endif
    tick();
    register1 = '0;
    check("alu_only_idle", 32'(RegWrite), 32'd0);
    check("alu_only_hold", 32'(writeRegister), 32'd5);

    // Conflicts: ALU, then MEM, then ALU again.
    drive_wb(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    #1;
    check("conf1_alu_ready", 32'(aluReady), 32'd1);
    check("conf1_mem_ready", 32'(memReady), 32'd0);
    expect_write(5'd3, 32'h33);
    tick();
    check("conf2_alu_ready", 32'(aluReady), 32'd0);
    check("conf2_mem_ready", 32'(memReady), 32'd1);
    expect_write(5'd4, 32'h44);
    tick();
    drive_wb(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    #1;
    check("conf3_alu_ready", 32'(aluReady), 32'd1);
    expect_write(5'd10, 32'hA0);
    tick();
    drive_wb(1'b0, '0, '0, 1'b1, 5'd11, 32'hB0);
    #1;
    check("lone_mem_ready", 32'(memReady), 32'd1);
    expect_write(5'd11, 32'hB0);
    tick();
    // Pointer still favours MEM: the lone MEM grant must not have moved it.
    drive_wb(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
    #1;
    check("conf4_mem_ready", 32'(memReady), 32'd1);
    check("conf4_alu_ready", 32'(aluReady), 32'd0);
    expect_write(5'd13, 32'hD0);
    tick();
    drive_wb(1'b1, 5'd12, 32'hC0, 1'b0, '0, '0);
    #1;
    check("conf4b_alu_ready", 32'(aluReady), 32'd1);
    expect_write(5'd12, 32'hC0);
    tick();
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    tick();

    // Scoreboard on register 7.
    issueValid = 1'b1;
    issueReg   = 5'd7;
    #1;
    check("issue7_ready", 32'(issueReady), 32'd1);
    tick();
    issueValid = 1'b0;
    register1  = 5'd7;
    #1;
    check("pending7_stall", 32'(readStall), 32'd1);
    check("reissue7_blocked", 32'(issueReady), 32'd0);
    drive_wb(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
    #1;
    check("mem7_ready", 32'(memReady), 32'd1);
    expect_write(5'd7, 32'h77);
    tick();
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
`ifdef REGFILE_WB_FORWARD_EN
    check("mem7_wcycle_stall", 32'(readStall), 32'd0);
    check("mem7_fwdsel1", 32'(fwdSel1), 32'd1);
    check("mem7_fwddata", fwdData, 32'h77);
`else
    check("mem7_wcycle_stall", 32'(readStall), 32'd1);
    check("mem7_fwddata", fwdData, 32'd0);
`endif
    check("mem7_fwdsel2", 32'(fwdSel2), 32'd0);
    tick();
    check("mem7_cleared", 32'(readStall), 32'd0);
    check("issue7_free", 32'(issueReady), 32'd1);

    // XZR.
    issueValid = 1'b1;
    issueReg   = 5'd31;
    #1;
    check("issue31_ready", 32'(issueReady), 32'd1);
    tick();
    issueValid = 1'b0;
    register1  = 5'd31;
    register2  = 5'd31;
    #1;
    check("xzr_no_stall", 32'(readStall), 32'd0);
    check("issue31_still_ready", 32'(issueReady), 32'd1);
    drive_wb(1'b1, 5'd31, 32'hDEAD, 1'b0, '0, '0);
    #1;
    check("alu31_ready", 32'(aluReady), 32'd1);
    tick();
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    check("alu31_no_write", 32'(RegWrite), 32'd0);
    check("alu31_hold_reg", 32'(writeRegister), 32'd7);
    check("xzr_r2_no_stall", 32'(readStall), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    issueValid = 1'b1;
    issueReg   = 5'd2;
    tick();
    issueReg   = 5'd9;
    tick();
    issueValid = 1'b0;
    register1  = 5'd2;
    register2  = 5'd9;
    #1;
    check("pre_reset_stall", 32'(readStall), 32'd1);
    drive_wb(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0);
    #1;
    rst_n = 1'b0;
    drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check("async_rst_stall", 32'(readStall), 32'd0);
    check("async_rst_regwrite", 32'(RegWrite), 32'd0);
    check("async_rst_wreg", 32'(writeRegister), 32'd0);
    check("async_rst_wdata", writeData, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("post_reset_stall", 32'(readStall), 32'd0);
    check("post_reset_regwrite", 32'(RegWrite), 32'd0);
    issueReg = 5'd2;
    #1;
    check("post_reset_issue2", 32'(issueReady), 32'd1);
    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
